dat_rx_buffer: RTL and testbench

//  Downstream of the DAT serial-to-parallel deserializer: captures each completed parallel word,

---
 rtl/dat_rx_buffer_pkg.sv | 21 ++
 rtl/dat_rx_fifo.sv | 54 +++++
 rtl/dat_rx_buffer.sv | 119 +++++++++++
 tb/tb_dat_rx_buffer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dat_rx_buffer_pkg.sv
// Shared definitions for the DAT receive buffer: default widths and FSM states.
package dat_rx_buffer_pkg;

    localparam int DAT_N           = 32;  // word width, matches the deserializer
    localparam int DAT_DEPTH       = 16;  // FIFO depth, power of two
    localparam int DAT_AW          = 4;   // log2(DAT_DEPTH)
    localparam int DAT_WCNT_W      = 8;   // block word counter width
    localparam int DAT_HOLD_MARGIN = 2;   // free slots left when clock_hold rises

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DONE    = 2'd2
    } rx_state_t;

    // Target word count: 0 encodes the full 2^wcnt_w range, so widen by one bit.
    function automatic logic [DAT_WCNT_W:0] block_target(input logic [DAT_WCNT_W-1:0] bw);
        return {(bw == '0), bw};
    endfunction

endpackage

// File: rtl/dat_rx_fifo.sv
// Synchronous FIFO with a registered read port.
// Ports:
//   sd_clock, reset (async, active-low)
//   wr_en/wr_data : write request; dropped when full unless a read occurs in the same cycle
//   rd_en/rd_data : read request; rd_data updates one cycle later, holds when empty
//   full, empty, level : occupancy derived from (AW+1)-bit pointers
module dat_rx_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          sd_clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         do_rd, do_wr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;

    // A read frees the head slot this cycle, so a write into a full FIFO is
    // accepted when paired with a read (both hit the same slot; read sees old data).
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    always_ff @(posedge sd_clock) begin
        if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) begin
                rd_data <= mem[rptr[AW-1:0]];
                rptr    <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dat_rx_buffer.sv
// DAT receive buffer: captures deserializer words on the rising edge of
// word_valid, counts words per block, buffers them for the host and raises
// clock_hold before the FIFO fills.
// Ports:
//   sd_clock, reset (async, active-low)
//   enable, block_words : block control; rising enable starts a block
//   word_in, word_valid : deserializer output and its completion flag
//   rd_en, rd_data      : host read port (1-cycle latency)
//   empty, full, level  : FIFO status
//   clock_hold          : stop-clock request, level >= DEPTH-HOLD_MARGIN
//   block_done          : 1-cycle pulse after the last word of a block
//   overflow            : sticky, a word was dropped; cleared at block start
module dat_rx_buffer
    import dat_rx_buffer_pkg::*;
#(
    parameter int n           = DAT_N,
    parameter int DEPTH       = DAT_DEPTH,
    parameter int AW          = DAT_AW,
    parameter int WCNT_W      = DAT_WCNT_W,
    parameter int HOLD_MARGIN = DAT_HOLD_MARGIN
) (
    input  logic              sd_clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [WCNT_W-1:0] block_words,
    input  logic [n-1:0]      word_in,
    input  logic              word_valid,
    input  logic              rd_en,
    output logic [n-1:0]      rd_data,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       level,
    output logic              clock_hold,
    output logic              block_done,
    output logic              overflow
);

    localparam logic [AW:0] HOLD_LVL = (AW+1)'(DEPTH - HOLD_MARGIN);

    rx_state_t       state_q, state_d;
    logic            wv_q, en_q;
    logic [WCNT_W:0] cnt, target, cnt_nxt;
    logic            capture, drop, start, last;

    // One word per 0->1 edge of word_valid, only while receiving.
    assign capture = word_valid & ~wv_q & (state_q == ST_RECEIVE);
    assign drop    = capture & full & ~rd_en;
    assign cnt_nxt = cnt + 1'b1;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && !en_q) begin
                    state_d = ST_RECEIVE;
                    start   = 1'b1;
                end
            end
            ST_RECEIVE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (capture && cnt_nxt == target) begin
                    state_d = ST_DONE;
                    last    = 1'b1;
                end
            end
            ST_DONE: begin
                if (!enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wv_q       <= 1'b0;
            en_q       <= 1'b0;
            cnt        <= '0;
            target     <= '0;
            block_done <= 1'b0;
            overflow   <= 1'b0;
            clock_hold <= 1'b0;
        end else begin
            state_q    <= state_d;
            wv_q       <= word_valid;
            en_q       <= enable;
            block_done <= last;
            clock_hold <= (level >= HOLD_LVL);
            if (start) begin
                target   <= block_target(block_words);
                cnt      <= '0;
                overflow <= 1'b0;
            end else if (capture) begin
                cnt <= cnt_nxt;
                if (drop) overflow <= 1'b1;
            end
        end
    end

    dat_rx_fifo #(
        .W     (n),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .sd_clock (sd_clock),
        .reset    (reset),
        .wr_en    (capture),
        .wr_data  (word_in),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

endmodule

// File: tb/tb_dat_rx_buffer.sv
// Directed bench for dat_rx_buffer (defaults: n=32, DEPTH=16, WCNT_W=8, HOLD_MARGIN=2).
module tb_dat_rx_buffer;

    logic        sd_clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  block_words;
    logic [31:0] word_in;
    logic        word_valid;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        empty, full;
    logic [4:0]  level;
    logic        clock_hold, block_done, overflow;

    int errors = 0;
    int checks = 0;

    always #5 sd_clock = ~sd_clock;

    dat_rx_buffer dut (
        .sd_clock    (sd_clock),
        .reset       (reset),
        .enable      (enable),
        .block_words (block_words),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .clock_hold  (clock_hold),
        .block_done  (block_done),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge sd_clock);
        #1;
    endtask

    // One word_valid pulse; block_done is checked right after the capture edge.
    task automatic push(input logic [31:0] w, input logic exp_bd);
        word_in    = w;
        word_valid = 1'b1;
        tick();
        chk("push_block_done", {31'd0, block_done}, {31'd0, exp_bd});
        word_valid = 1'b0;
        tick();
    endtask

    task automatic pop(input string tag, input logic [31:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk(tag, rd_data, exp);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; block_words = 8'd0;
        word_in = '0; word_valid = 1'b0; rd_en = 1'b0;
        #12;
        // reset state
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_hold", {31'd0, clock_hold}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_block_done", {31'd0, block_done}, 32'd0);
        reset = 1'b1;
        tick();

        // 1: four-word block, in-order readback
        block_words = 8'd4; enable = 1'b1;
        tick();
        push(32'hA0, 1'b0);
        push(32'hA1, 1'b0);
        push(32'hA2, 1'b0);
        push(32'hA3, 1'b1);
        chk("t1_done_1cyc", {31'd0, block_done}, 32'd0);
        chk("t1_level", {27'd0, level}, 32'd4);
        push(32'hAF, 1'b0);                       // DONE ignores captures
        chk("t1_done_ignores", {27'd0, level}, 32'd4);
        enable = 1'b0;
        tick();
        pop("t1_rd0", 32'hA0);
        pop("t1_rd1", 32'hA1);
        pop("t1_rd2", 32'hA2);
        pop("t1_rd3", 32'hA3);
        chk("t1_empty", {31'd0, empty}, 32'd1);
        pop("t1_rd_empty_hold", 32'hA3);

        // 2: word_valid held high for 5 cycles yields one word
        enable = 1'b1;
        tick();
        word_in = 32'hB0; word_valid = 1'b1;
        repeat (5) tick();
        word_valid = 1'b0;
        tick();
        chk("t2_level", {27'd0, level}, 32'd1);
        pop("t2_rd", 32'hB0);
        enable = 1'b0;
        tick();

        // 3: fill without reads (block_words=0 -> 256-word block)
        block_words = 8'd0; enable = 1'b1;
        tick();
        for (int i = 0; i < 13; i++) push(32'hC0 + i, 1'b0);
        chk("t3_hold_13", {31'd0, clock_hold}, 32'd0);
        push(32'hCD, 1'b0);
        chk("t3_hold_14", {31'd0, clock_hold}, 32'd1);
        push(32'hCE, 1'b0);
        push(32'hCF, 1'b0);
        chk("t3_full", {31'd0, full}, 32'd1);
        chk("t3_ovf_before", {31'd0, overflow}, 32'd0);
        push(32'hEE, 1'b0);                       // 17th word is dropped
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        chk("t3_level16", {27'd0, level}, 32'd16);
        pop("t3_rd", 32'hC0);
        chk("t3_level15", {27'd0, level}, 32'd15);
        tick();
        chk("t3_hold_15", {31'd0, clock_hold}, 32'd1);

        // 4: restart clears overflow; full + simultaneous read/write across wrap
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        chk("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
        push(32'hD0, 1'b0);
        chk("t4_full", {31'd0, full}, 32'd1);
        word_in = 32'hD1; word_valid = 1'b1; rd_en = 1'b1;
        tick();
        word_valid = 1'b0; rd_en = 1'b0;
        chk("t4_rw_rd", rd_data, 32'hC1);
        chk("t4_rw_level", {27'd0, level}, 32'd16);
        chk("t4_rw_ovf", {31'd0, overflow}, 32'd0);
        tick();
        for (int i = 2; i < 16; i++) pop("t4_drain_c", 32'hC0 + i);
        pop("t4_drain_d0", 32'hD0);
        pop("t4_drain_d1", 32'hD1);
        chk("t4_empty", {31'd0, empty}, 32'd1);
        tick();
        chk("t4_hold_off", {31'd0, clock_hold}, 32'd0);

        // 5: enable dropped mid-block
        enable = 1'b0;
        tick();
        block_words = 8'd4; enable = 1'b1;
        tick();
        push(32'hE0, 1'b0);
        push(32'hE1, 1'b0);
        enable = 1'b0;
        tick();
        chk("t5_no_done", {31'd0, block_done}, 32'd0);
        push(32'hE2, 1'b0);                       // IDLE: not captured
        chk("t5_level", {27'd0, level}, 32'd2);
        pop("t5_rd0", 32'hE0);
        pop("t5_rd1", 32'hE1);
        chk("t5_empty", {31'd0, empty}, 32'd1);

        // 6: asynchronous reset mid-block
        enable = 1'b1;
        tick();
        push(32'hF0, 1'b0);
        push(32'hF1, 1'b0);
        chk("t6_level_pre", {27'd0, level}, 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("t6_empty", {31'd0, empty}, 32'd1);
        chk("t6_level", {27'd0, level}, 32'd0);
        chk("t6_rd_data", rd_data, 32'd0);
        chk("t6_hold", {31'd0, clock_hold}, 32'd0);
        chk("t6_overflow", {31'd0, overflow}, 32'd0);
        enable = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
